// File: rtl/alu_pkg.sv
// Shared ALU operation codes, instruction-format codes and RV major opcodes.
// Used by the decode stage and the downstream ALU.
package alu_pkg;

   typedef logic [10:0] alu_op_t;
   typedef logic [3:0]  itype_t;

   localparam alu_op_t ALU_NOTHING = 11'd0;
   localparam alu_op_t ALU_ADD     = 11'd1;
   localparam alu_op_t ALU_SUB     = 11'd2;
   localparam alu_op_t ALU_SLL     = 11'd3;
   localparam alu_op_t ALU_SRL     = 11'd4;
   localparam alu_op_t ALU_SRA     = 11'd5;
   localparam alu_op_t ALU_LESS    = 11'd6;
   localparam alu_op_t ALU_LESSU   = 11'd7;
   localparam alu_op_t ALU_SLTIU   = ALU_LESSU;
   localparam alu_op_t ALU_XOR     = 11'd8;
   localparam alu_op_t ALU_OR      = 11'd9;
   localparam alu_op_t ALU_AND     = 11'd10;
   localparam alu_op_t ALU_EQUAL   = 11'd11;
   localparam alu_op_t ALU_NEQ     = 11'd12;
   localparam alu_op_t ALU_GTE     = 11'd13;
   localparam alu_op_t ALU_GTEU    = 11'd14;
   localparam alu_op_t ALU_MUL     = 11'd15;
   localparam alu_op_t ALU_MULH    = 11'd16;
   localparam alu_op_t ALU_MULHSU  = 11'd17;
   localparam alu_op_t ALU_MULHU   = 11'd18;
   localparam alu_op_t ALU_DIV     = 11'd19;
   localparam alu_op_t ALU_DIVU    = 11'd20;
   localparam alu_op_t ALU_REM     = 11'd21;
   localparam alu_op_t ALU_REMU    = 11'd22;

   localparam itype_t NONE  = 4'd0;
   localparam itype_t RTYPE = 4'd1;
   localparam itype_t ITYPE = 4'd2;
   localparam itype_t STYPE = 4'd3;
   localparam itype_t BTYPE = 4'd4;
   localparam itype_t UTYPE = 4'd5;
   localparam itype_t JTYPE = 4'd6;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef struct packed {
      alu_op_t     op;
      itype_t      itype;
      logic [31:0] imm;
      logic [5:0]  shamt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational RV64 instruction decoder producing ALU op, format, immediate and registers.
// Define RV64M_EN to decode the M-extension multiply/divide group on OP.
module instr_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   alu_op_t     op;
   itype_t      ty;
   logic [31:0] imm;
   logic        ill, use_rs1, use_rs2, use_rd;

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      op      = ALU_ADD;
      ty      = NONE;
      imm     = '0;
      ill     = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opc)
         OPC_OP: begin
            ty = RTYPE; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            case (f7)
               7'b0000000: case (f3)
                  3'd0: op = ALU_ADD;   3'd1: op = ALU_SLL;
                  3'd2: op = ALU_LESS;  3'd3: op = ALU_LESSU;
                  3'd4: op = ALU_XOR;   3'd5: op = ALU_SRL;
                  3'd6: op = ALU_OR;    default: op = ALU_AND;
               endcase
               7'b0100000: begin
                  if (f3 == 3'd0)      op = ALU_SUB;
                  else if (f3 == 3'd5) op = ALU_SRA;
                  else                 ill = 1'b1;
               end
`ifdef RV64M_EN
               7'b0000001: case (f3)
                  3'd0: op = ALU_MUL;   3'd1: op = ALU_MULH;
                  3'd2: op = ALU_MULHSU; 3'd3: op = ALU_MULHU;
                  3'd4: op = ALU_DIV;   3'd5: op = ALU_DIVU;
                  3'd6: op = ALU_REM;   default: op = ALU_REMU;
               endcase
`endif
               default: ill = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            ty = ITYPE; imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            case (f3)
               3'd0: op = ALU_ADD;   3'd2: op = ALU_LESS;
               3'd3: op = ALU_SLTIU; 3'd4: op = ALU_XOR;
               3'd6: op = ALU_OR;    3'd7: op = ALU_AND;
               3'd1: begin
                  op  = ALU_SLL;
                  ill = (instr[31:26] != 6'b000000);
               end
               default: begin
                  // RV64 shifts use a 6-bit shamt, so funct6 picks logical vs arithmetic
                  if (instr[31:26] == 6'b000000)      op = ALU_SRL;
                  else if (instr[31:26] == 6'b010000) op = ALU_SRA;
                  else                                ill = 1'b1;
               end
            endcase
         end
         OPC_LOAD: begin
            ty = ITYPE; imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            ill = (f3 == 3'd7);
         end
         OPC_STORE: begin
            ty = STYPE; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            ill = f3[2];
         end
         OPC_BRANCH: begin
            ty = BTYPE; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'd0: op = ALU_EQUAL; 3'd1: op = ALU_NEQ;
               3'd4: op = ALU_LESS;  3'd5: op = ALU_GTE;
               3'd6: op = ALU_LESSU; 3'd7: op = ALU_GTEU;
               default: ill = 1'b1;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            ty = UTYPE; imm = imm_u; use_rd = 1'b1;
         end
         OPC_JAL: begin
            ty = JTYPE; imm = imm_j; use_rd = 1'b1;
         end
         OPC_JALR: begin
            ty = ITYPE; imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
            ill = (f3 != 3'd0);
         end
         default: ill = 1'b1;
      endcase

      dec.illegal = ill;
      dec.op      = ill ? ALU_NOTHING : op;
      dec.itype   = ill ? NONE : ty;
      dec.imm     = ill ? 32'h0 : imm;
      dec.shamt   = instr[25:20];
      dec.rs1     = (use_rs1 && !ill) ? instr[19:15] : 5'd0;
      dec.rs2     = (use_rs2 && !ill) ? instr[24:20] : 5'd0;
      dec.rd      = (use_rd  && !ill) ? instr[11:7]  : 5'd0;
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: output register plus one-entry skid buffer around instr_decode.
// RV64M_EN (see instr_decode) enables M-extension decoding.
module decode_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [10:0]     opcode,
   output logic [3:0]      instr_type,
   output logic [31:0]     immediate,
   output logic [5:0]      shamt,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] pc_out,
   output logic            illegal
);

   dec_t            dec;
   dec_t            out_q, out_d, sk_q, sk_d;
   logic [XLEN-1:0] pc_q, pc_d, skpc_q, skpc_d;
   logic            ov_q, ov_d, sv_q, sv_d;
   logic            retire;

   instr_decode u_dec (.instr(instr), .dec(dec));

   assign retire = ov_q & out_ready;

   always_comb begin
      out_d  = out_q;
      pc_d   = pc_q;
      sk_d   = sk_q;
      skpc_d = skpc_q;
      ov_d   = ov_q;
      sv_d   = sv_q;
      if (flush) begin
         ov_d = 1'b0;
         sv_d = 1'b0;
      end else if (!ov_q || retire) begin
         // Output slot frees: skid has priority; input is only accepted when skid is empty
         if (sv_q) begin
            out_d = sk_q;
            pc_d  = skpc_q;
            ov_d  = 1'b1;
            sv_d  = 1'b0;
         end else if (in_valid) begin
            out_d = dec;
            pc_d  = pc_in;
            ov_d  = 1'b1;
         end else begin
            ov_d  = 1'b0;
         end
      end else if (in_valid && !sv_q) begin
         sk_d   = dec;
         skpc_d = pc_in;
         sv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= '0;
         pc_q   <= '0;
         sk_q   <= '0;
         skpc_q <= '0;
         ov_q   <= 1'b0;
         sv_q   <= 1'b0;
      end else begin
         out_q  <= out_d;
         pc_q   <= pc_d;
         sk_q   <= sk_d;
         skpc_q <= skpc_d;
         ov_q   <= ov_d;
         sv_q   <= sv_d;
      end
   end

   assign in_ready   = ~sv_q;
   assign out_valid  = ov_q;
   assign opcode     = out_q.op;
   assign instr_type = out_q.itype;
   assign immediate  = out_q.imm;
   assign shamt      = out_q.shamt;
   assign rs1        = out_q.rs1;
   assign rs2        = out_q.rs2;
   assign rd         = out_q.rd;
   assign illegal    = out_q.illegal;
   assign pc_out     = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode vectors, handshake, stall, flush, reset.
module tb_decode_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] instr, immediate;
   logic [63:0] pc_in, pc_out;
   logic [10:0] opcode;
   logic [3:0]  instr_type;
   logic [5:0]  shamt;
   logic [4:0]  rs1, rs2, rd;
   int          checks = 0;
   int          errors = 0;

   decode_stage #(.XLEN(64)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .instr_type(instr_type), .immediate(immediate), .shamt(shamt),
      .rs1(rs1), .rs2(rs2), .rd(rd), .pc_out(pc_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic [63:0] pc);
      in_valid = 1'b1;
      instr    = w;
      pc_in    = pc;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dec(input string tag, input logic [10:0] op, input logic [3:0] ty,
                          input logic [31:0] imm, input logic [4:0] e_rs1,
                          input logic [4:0] e_rs2, input logic [4:0] e_rd, input logic ill);
      chk({tag, ".valid"},   out_valid,  1);
      chk({tag, ".opcode"},  opcode,     op);
      chk({tag, ".type"},    instr_type, ty);
      chk({tag, ".imm"},     immediate,  imm);
      chk({tag, ".rs1"},     rs1,        e_rs1);
      chk({tag, ".rs2"},     rs2,        e_rs2);
      chk({tag, ".rd"},      rd,         e_rd);
      chk({tag, ".illegal"}, illegal,    ill);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; out_ready = 1'b1;
      #12;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready",  in_ready,  1);
      chk("rst.opcode",    opcode,    0);
      chk("rst.imm",       immediate, 0);
      chk("rst.pc",        pc_out,    0);
      reset_n = 1'b1;

      // addi x1,x0,5 then back-to-back add / slli with out_ready held high
      send(32'h00500093, 64'h100); tick();
      chk_dec("addi", ALU_ADD, ITYPE, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0);
      chk("addi.pc", pc_out, 64'h100);
      send(32'h002081B3, 64'h104); tick();
      chk_dec("add", ALU_ADD, RTYPE, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      chk("add.pc", pc_out, 64'h104);
      send(32'h03F09093, 64'h108); tick();
      chk_dec("slli", ALU_SLL, ITYPE, 32'd63, 5'd1, 5'd0, 5'd1, 1'b0);
      chk("slli.shamt", shamt, 6'd63);
      chk("slli.pc", pc_out, 64'h108);

      send(32'h027302B3, 64'h10C); tick();
`ifdef RV64M_EN
      chk_dec("mul", ALU_MUL, RTYPE, 32'd0, 5'd6, 5'd7, 5'd5, 1'b0);
`else
      chk_dec("mul", ALU_NOTHING, NONE, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
`endif

      // immediate formats and remaining opcode groups, one per cycle
      send(32'hFE512E23, 64'h110); tick();
      chk_dec("sw", ALU_ADD, STYPE, 32'hFFFFFFFC, 5'd2, 5'd5, 5'd0, 1'b0);
      send(32'hFE209CE3, 64'h114); tick();
      chk_dec("bne", ALU_NEQ, BTYPE, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, 1'b0);
      send(32'h0041F863, 64'h118); tick();
      chk_dec("bgeu", ALU_GTEU, BTYPE, 32'd16, 5'd3, 5'd4, 5'd0, 1'b0);
      send(32'h001000EF, 64'h11C); tick();
      chk_dec("jal", ALU_ADD, JTYPE, 32'h00000800, 5'd0, 5'd0, 5'd1, 1'b0);
      send(32'h123452B7, 64'h120); tick();
      chk_dec("lui", ALU_ADD, UTYPE, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b0);
      send(32'h409403B3, 64'h124); tick();
      chk_dec("sub", ALU_SUB, RTYPE, 32'd0, 5'd8, 5'd9, 5'd7, 1'b0);
      send(32'h4030D093, 64'h128); tick();
      chk_dec("srai", ALU_SRA, ITYPE, 32'h00000403, 5'd1, 5'd0, 5'd1, 1'b0);
      chk("srai.shamt", shamt, 6'd3);
      send(32'h00000000, 64'h12C); tick();
      chk_dec("zero", ALU_NOTHING, NONE, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
      chk("zero.pc", pc_out, 64'h12C);
      in_valid = 1'b0; tick();
      chk("drain.out_valid", out_valid, 0);

      // stall: two accepted, third refused, then both drain in order
      out_ready = 1'b0;
      send(32'h002081B3, 64'h200); tick();
      chk("stall1.in_ready", in_ready, 1);
      chk("stall1.pc", pc_out, 64'h200);
      send(32'h00500093, 64'h204); tick();
      chk("stall2.in_ready", in_ready, 0);
      chk_dec("stall2.hold", ALU_ADD, RTYPE, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      chk("stall2.pc", pc_out, 64'h200);
      send(32'h03F09093, 64'h208); tick();
      chk("stall3.in_ready", in_ready, 0);
      chk_dec("stall3.hold", ALU_ADD, RTYPE, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      chk("stall3.pc", pc_out, 64'h200);
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk_dec("skid", ALU_ADD, ITYPE, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0);
      chk("skid.pc", pc_out, 64'h204);
      chk("skid.in_ready", in_ready, 1);
      tick();
      chk("stall.drained", out_valid, 0);

      // flush while output full, skid empty, with a same-cycle accept
      out_ready = 1'b0;
      send(32'h002081B3, 64'h300); tick();
      send(32'h00500093, 64'h304); flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush1.out_valid", out_valid, 0);
      chk("flush1.in_ready", in_ready, 1);
      out_ready = 1'b1; tick();
      chk("flush1.nothing", out_valid, 0);

      // flush with both entries held and in_valid asserted
      out_ready = 1'b0;
      send(32'h002081B3, 64'h400); tick();
      send(32'h00500093, 64'h404); tick();
      chk("flush2.full", in_ready, 0);
      send(32'h03F09093, 64'h408); flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush2.out_valid", out_valid, 0);
      chk("flush2.in_ready", in_ready, 1);
      out_ready = 1'b1; tick();
      chk("flush2.nothing", out_valid, 0);

      // asynchronous reset in the middle of a full stall
      out_ready = 1'b0;
      send(32'h002081B3, 64'h500); tick();
      send(32'h00500093, 64'h504); tick();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst2.out_valid", out_valid, 0);
      chk("rst2.in_ready", in_ready, 1);
      chk("rst2.imm", immediate, 0);
      chk("rst2.pc", pc_out, 0);
      #1 reset_n = 1'b1;
      send(32'h00500093, 64'h600); tick();
      chk_dec("post_rst", ALU_ADD, ITYPE, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0);
      chk("post_rst.pc", pc_out, 64'h600);
      in_valid = 1'b0; out_ready = 1'b1; tick();
      chk("post_rst.drained", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of PC path.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  fetch word present.
- in_ready  output  1  stage can accept.
- instr  input  32  RV64 instruction word.
- pc_in  input  XLEN  instruction address.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  ALU/execute stage accepts.
- opcode  output  11  ALU operation code from alu_pkg.
- instr_type  output  4  RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE/NONE code.
- immediate  output  32  sign-extended immediate.
- shamt  output  6  shift amount, instr[25:20].
- rs1, rs2, rd  output  5 each  register indices.
- pc_out  output  XLEN  PC of the presented entry.
- illegal  output  1  word not decodable.

Function
REQ-003 SHALL accept a word when in_valid && in_ready; it SHALL appear on the outputs with out_valid=1 exactly one cycle later if the output slot is free.
REQ-004 SHALL retire an entry when out_valid && out_ready.
REQ-005 SHALL contain an output register plus a one-entry skid buffer; in_ready SHALL equal NOT skid_valid, registered (no combinational out_ready-to-in_ready path).
REQ-006 Output held while out_ready=0: all outputs SHALL remain stable until retired.
REQ-007 Accept while output full and stalled: entry SHALL go to skid; skid SHALL move to output the cycle the output entry retires.
REQ-008 Simultaneous accept and retire with skid empty: new entry SHALL replace the output entry, sustaining one entry per cycle.
REQ-009 Order SHALL be preserved; no entry dropped or duplicated except by flush.
REQ-010 flush=1 SHALL clear output and skid valids next edge; an input accepted in the same cycle SHALL be discarded.
REQ-011 Immediates: I/S/B/U/J formats per RV64 base ISA, sign-extended to 32 bits; B and J include bit 0 = 0.
REQ-012 OP/OP-IMM funct3/funct7 SHALL map to ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LESS, ALU_SLTIU/ALU_LESSU, ALU_XOR, ALU_OR, ALU_AND; loads/stores SHALL map to ALU_ADD with ITYPE/STYPE.
REQ-013 Branches SHALL map BEQ->ALU_EQUAL, BNE->ALU_NEQ, BLT->ALU_LESS, BGE->ALU_GTE, BLTU->ALU_LESSU, BGEU->ALU_GTEU with BTYPE.
REQ-014 Unknown major opcode or funct combination: illegal=1, opcode=ALU_NOTHING, instr_type=NONE; entry SHALL still flow through the handshake.
REQ-015 Unused register fields SHALL be output as 0.

Reset
REQ-016 reset_n low SHALL asynchronously clear out_valid and skid_valid and set in_ready=1; data outputs SHALL be 0.
REQ-017 Reset mid-stall SHALL discard both entries; first accept SHALL be possible the first edge after reset_n rises.

Configuration
REQ-018 With RV64M_EN defined, funct7=0000001 on OP SHALL decode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to the matching ALU_ codes, RTYPE.
REQ-019 Without RV64M_EN, those encodings SHALL decode as illegal per REQ-014.

Structure
REQ-020 alu_pkg SHALL hold ALU opcode constants, instr_type constants and RV major-opcode constants, shared with the ALU.
REQ-021 Pure decode logic SHALL be a combinational sub-module instr_decode; decode_stage SHALL hold only handshake and storage.

Verification
REQ-022 instr=0x00500093 -> next cycle out_valid=1, opcode=ALU_ADD, ITYPE, immediate=5, rd=1, rs1=0.
REQ-023 instr=0x002081B3 then 0x03F09093 back-to-back, out_ready=1 -> ALU_ADD RTYPE rd=3, then ALU_SLL ITYPE shamt=63; one per cycle.
REQ-024 instr=0x027302B3 -> ALU_MUL RTYPE rd=5 with RV64M_EN; illegal=1, ALU_NOTHING without.
REQ-025 out_ready=0, two words accepted -> in_ready=0 after the second, outputs stable; out_ready=1 -> both emerge in order.
REQ-026 instr=0x00000000 -> illegal=1; flush during stall with in_valid=1 -> out_valid=0 next cycle, nothing emerges.
